nrisc_multicycle_ctrl: RTL

NRISC_MULTICYCLE_CTRL -- requirements
Module: nrisc_multicycle_ctrl

---
 rtl/nrisc_pkg.sv | 18 +
 rtl/nrisc_decode.sv | 36 +++
 rtl/nrisc_multicycle_ctrl.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/nrisc_pkg.sv
// Shared opcode constants and FSM state encoding for the nRISC multicycle controller.
package nrisc_pkg;

  localparam logic [2:0] OP_LI   = 3'b011;
  localparam logic [2:0] OP_SW   = 3'b100;
  localparam logic [2:0] OP_LW   = 3'b101;
  localparam logic [2:0] OP_HALT = 3'b111;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_LI_IMM = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_t;

endpackage

// File: rtl/nrisc_decode.sv
// Combinational field extraction for an nRISC instruction word: opcode, ra, rb and opcode class flags.
module nrisc_decode
  import nrisc_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int REG_IDX_W = 3
) (
  input  logic [DATA_W-1:0]    instr,
  output logic [2:0]           opcode,
  output logic [REG_IDX_W-1:0] ra,
  output logic [REG_IDX_W-1:0] rb,
  output logic                 is_li,
  output logic                 is_sw,
  output logic                 is_lw,
  output logic                 is_halt
);

  localparam int RB_W = DATA_W - 3 - REG_IDX_W;

  assign opcode = instr[DATA_W-1 -: 3];
  assign ra     = instr[DATA_W-4 -: REG_IDX_W];

  // rb holds whatever low bits remain below ra, zero-extended to a full index
  always_comb begin
    rb = '0;
    for (int i = 0; i < REG_IDX_W; i++) begin
      if (i < RB_W) rb[i] = instr[i];
    end
  end

  assign is_li   = (opcode == OP_LI);
  assign is_sw   = (opcode == OP_SW);
  assign is_lw   = (opcode == OP_LW);
  assign is_halt = (opcode == OP_HALT);

endmodule

// File: rtl/nrisc_multicycle_ctrl.sv
// Multicycle nRISC controller: FETCH/DECODE/LI_IMM/MEM/WB/HALT sequencing of PC, register file and data memory.
// Define NRISC_MEM_WAIT_EN to make MEM wait for dm_ack; otherwise MEM is a fixed single cycle.
module nrisc_multicycle_ctrl
  import nrisc_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int REG_IDX_W = 3,
  parameter int ADDR_W    = 8
) (
  input  logic                 CLOCK,
  input  logic                 RESET,
  output logic [ADDR_W-1:0]    pc_out,
  input  logic [DATA_W-1:0]    instr_in,
  output logic [REG_IDX_W-1:0] rf_raddr_a,
  output logic [REG_IDX_W-1:0] rf_raddr_b,
  input  logic [DATA_W-1:0]    rf_rdata_a,
  input  logic [DATA_W-1:0]    rf_rdata_b,
  output logic                 rf_we,
  output logic [REG_IDX_W-1:0] rf_waddr,
  output logic [DATA_W-1:0]    rf_wdata,
  output logic                 dm_req,
  output logic                 dm_we,
  output logic [ADDR_W-1:0]    dm_addr,
  output logic [DATA_W-1:0]    dm_wdata,
  input  logic [DATA_W-1:0]    dm_rdata,
  input  logic                 dm_ack,
  output logic                 halted
);

  state_t              state;
  logic [ADDR_W-1:0]   pc;
  logic [DATA_W-1:0]   ir;
  logic [DATA_W-1:0]   mem_data;
  logic [2:0]          opcode;
  logic [REG_IDX_W-1:0] ra;
  logic [REG_IDX_W-1:0] rb;
  logic                is_li;
  logic                is_sw;
  logic                is_lw;
  logic                is_halt;
  logic                mem_done;

  nrisc_decode #(
    .DATA_W    (DATA_W),
    .REG_IDX_W (REG_IDX_W)
  ) u_decode (
    .instr   (ir),
    .opcode  (opcode),
    .ra      (ra),
    .rb      (rb),
    .is_li   (is_li),
    .is_sw   (is_sw),
    .is_lw   (is_lw),
    .is_halt (is_halt)
  );

`ifdef NRISC_MEM_WAIT_EN
  assign mem_done = dm_ack;
`else
  logic unused_ack;
  assign unused_ack = dm_ack;
  assign mem_done   = 1'b1;
`endif

  assign pc_out     = pc;
  assign rf_raddr_a = ra;
  assign rf_raddr_b = rb;
  assign rf_waddr   = ra;
  // LI writes the immediate straight from the fetch port; WB writes the captured load data
  assign rf_wdata   = (state == ST_LI_IMM) ? instr_in : mem_data;

  // Request outputs are set on entry to their state so they are glitch-free and stable throughout
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state    <= ST_FETCH;
      pc       <= '0;
      ir       <= '0;
      mem_data <= '0;
      halted   <= 1'b0;
      rf_we    <= 1'b0;
      dm_req   <= 1'b0;
      dm_we    <= 1'b0;
      dm_addr  <= '0;
      dm_wdata <= '0;
    end else begin
      unique case (state)
        ST_FETCH: begin
          ir    <= instr_in;
          state <= ST_DECODE;
        end
        ST_DECODE: begin
          if (is_li) begin
            pc    <= pc + ADDR_W'(1);
            rf_we <= 1'b1;
            state <= ST_LI_IMM;
          end else if (is_sw || is_lw) begin
            dm_req   <= 1'b1;
            dm_we    <= is_sw;
            dm_addr  <= rf_rdata_b[ADDR_W-1:0];
            dm_wdata <= rf_rdata_a;
            state    <= ST_MEM;
          end else if (is_halt) begin
            halted <= 1'b1;
            state  <= ST_HALT;
          end else begin
            pc    <= pc + ADDR_W'(1);
            state <= ST_FETCH;
          end
        end
        ST_LI_IMM: begin
          rf_we <= 1'b0;
          pc    <= pc + ADDR_W'(1);
          state <= ST_FETCH;
        end
        ST_MEM: begin
          if (mem_done) begin
            dm_req <= 1'b0;
            dm_we  <= 1'b0;
            if (is_sw) begin
              pc    <= pc + ADDR_W'(1);
              state <= ST_FETCH;
            end else begin
              mem_data <= dm_rdata;
              rf_we    <= 1'b1;
              state    <= ST_WB;
            end
          end
        end
        ST_WB: begin
          rf_we <= 1'b0;
          pc    <= pc + ADDR_W'(1);
          state <= ST_FETCH;
        end
        ST_HALT: begin
          state <= ST_HALT;
        end
        default: begin
          state <= ST_FETCH;
        end
      endcase
    end
  end

endmodule
